// File: rtl/ge_round_sequencer.sv
// ge_round_sequencer
//   Sequences the GE evaluation chain (commute -> exam -> presentation) over a
//   campaign of ROUNDS rounds. Each stage is requested from an external
//   evaluator, its pass/bonus result is captured on acknowledge, and a round
//   is aborted early as soon as one stage fails or times out. Campaign
//   statistics (passed rounds, failed rounds, saturating bonus sum) are kept
//   and hold after the campaign until the next start.
//
//   Optional build macro: GE_ROUND_LOG_EN
//     defined   -> round_log keeps a per-round pass bitmap
//     undefined -> round_log is tied to 0 and no log registers exist
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   campaign start pulse, honoured only in IDLE
//   stage_req    out  request to the evaluator for stage_sel
//   stage_sel    out  1=commute 2=exam 3=presentation, 0 otherwise
//   bonus_fwd    out  bonus of the previous passed stage of this round
//   stage_ack    in   evaluator result valid
//   stage_pass   in   evaluator pass result (valid with stage_ack)
//   stage_bonus  in   evaluator bonus result (valid with stage_ack)
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at campaign end
//   round_idx    out  current round, 0-based
//   pass_cnt     out  rounds passed (saturating)
//   fail_cnt     out  rounds failed (saturating)
//   bonus_acc    out  sum of exam bonus over passed rounds (saturating)
//   timeout_flag out  sticky stage-timeout indicator, cleared by start/rst
//   round_log    out  per-round pass bitmap (GE_ROUND_LOG_EN only)

module ge_round_sequencer #(
  parameter int ROUNDS  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              stage_req,
  output logic [1:0]        stage_sel,
  output logic [1:0]        bonus_fwd,
  input  logic              stage_ack,
  input  logic              stage_pass,
  input  logic [1:0]        stage_bonus,
  output logic              busy,
  output logic              done,
  output logic [7:0]        round_idx,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W+1:0]  bonus_acc,
  output logic              timeout_flag,
  output logic [ROUNDS-1:0] round_log
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [7:0]        LAST_ROUND = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, NEXT, DONE} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        bonus2;      // exam bonus held for accumulation in NEXT
  logic              round_pass;  // result of the round being closed in NEXT

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W+1:0] sat_add(input logic [CNT_W+1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W+2:0] s;
    s = {1'b0, a} + {{(CNT_W + 1){1'b0}}, b};
    return s[CNT_W+2] ? '1 : s[CNT_W+1:0];
  endfunction

  // Outputs decode straight from the state register.
  assign stage_req = (state == S1) || (state == S2) || (state == S3);
  assign stage_sel = (state == S1) ? 2'd1 :
                     (state == S2) ? 2'd2 :
                     (state == S3) ? 2'd3 : 2'd0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      round_idx    <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      bonus_acc    <= '0;
      timeout_flag <= 1'b0;
      bonus_fwd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= S1;
            wait_cnt     <= '0;
            round_idx    <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            bonus_acc    <= '0;
            timeout_flag <= 1'b0;
            bonus_fwd    <= '0;
          end
        end
        S1, S2, S3: begin
          // An acknowledge in the last wait cycle still wins over the timeout.
          if (stage_ack) begin
            wait_cnt <= '0;
            if (!stage_pass) begin
              round_pass <= 1'b0;
              state      <= NEXT;
            end else if (state == S1) begin
              bonus_fwd <= stage_bonus;
              state     <= S2;
            end else if (state == S2) begin
              bonus_fwd <= stage_bonus;
              bonus2    <= stage_bonus;
              state     <= S3;
            end else begin
              round_pass <= 1'b1;
              state      <= NEXT;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt     <= '0;
            round_pass   <= 1'b0;
            timeout_flag <= 1'b1;
            state        <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (round_pass) begin
            pass_cnt  <= sat_inc(pass_cnt);
            bonus_acc <= sat_add(bonus_acc, bonus2);
          end else begin
            fail_cnt <= sat_inc(fail_cnt);
          end
          bonus_fwd <= '0;
          if (round_idx == LAST_ROUND) begin
            state <= DONE;
          end else begin
            round_idx <= round_idx + 8'd1;
            state     <= S1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GE_ROUND_LOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      round_log <= '0;
    end else if (state == IDLE && start) begin
      round_log <= '0;
    end else if (state == NEXT) begin
      for (int i = 0; i < ROUNDS; i++) begin
        if (round_idx == 8'(i)) round_log[i] <= round_pass;
      end
    end
  end
`else
  assign round_log = '0;
`endif

endmodule
